// File: rtl/noc_pkg.sv
// Shared router definitions: default port count, index width, output lock state
// and a small request-legality helper.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 7;
  localparam int unsigned PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } out_state_e;

  // True when at most one bit of v is set.
  function automatic logic onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Allocator <-> input buffers / crossbar handshake bundle.
interface switch_allocator_if
  import noc_pkg::*;
#(
  parameter int unsigned P = NUM_PORTS
);

  logic [P-1:0]   in_valid_all;
  logic [P-1:0]   in_head_all;
  logic [P-1:0]   in_tail_all;
  logic [P*P-1:0] route_req_all;
  logic [P-1:0]   out_ready_all;
  logic [P*P-1:0] grant_outport_all;
  logic [P-1:0]   in_pop_all;

  modport master (
    output in_valid_all, in_head_all, in_tail_all, route_req_all, out_ready_all,
    input  grant_outport_all, in_pop_all
  );

  modport slave (
    input  in_valid_all, in_head_all, in_tail_all, route_req_all, out_ready_all,
    output grant_outport_all, in_pop_all
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, searching
// upward modulo P.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter  int unsigned P     = NUM_PORTS,
  localparam int unsigned IDX_W = (P > 1) ? $clog2(P) : 1
) (
  input  logic [P-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [P-1:0]     grant
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < P; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= P) idx = idx - P;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin among head flits, output
// locked to its owner until the tail crosses, one-hot crossbar selects and pops.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int unsigned P = NUM_PORTS
) (
  input  logic                clk,
  input  logic                rst_n,
  switch_allocator_if.slave   alloc_if,
  output logic [P-1:0]        out_busy_all,
  output logic                proto_err
);

  localparam int unsigned IDX_W = (P > 1) ? $clog2(P) : 1;

  logic [P-1:0]     legal;
  logic [P-1:0]     locked;
  logic [P-1:0]     owned;
  logic [IDX_W-1:0] owner_of [P];
  logic [P*P-1:0]   grant_all;
  logic [P-1:0]     pop;
  logic             err_d;

  always_comb begin
    legal = '0;
    for (int unsigned i = 0; i < P; i++)
      legal[i] = onehot0(32'(alloc_if.route_req_all[i*P +: P]));
  end

  for (genvar o = 0; o < P; o++) begin : g_out
    out_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d, ptr_q, ptr_d, win_idx;
    logic [P-1:0]     cand, rr_grant, grant;
    logic             win_tail;

    // Multi-hot requests are excluded here so they can never win.
    always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < P; i++)
        cand[i] = alloc_if.in_valid_all[i] & legal[i] & alloc_if.route_req_all[i*P + o];
    end

    rr_arbiter #(.P(P)) u_rr (
      .req   (cand & alloc_if.in_head_all),
      .ptr   (ptr_q),
      .grant (rr_grant)
    );

    always_comb begin
      grant = '0;
      if (rst_n && alloc_if.out_ready_all[o]) begin
        if (state_q == IDLE)      grant = rr_grant;
        else if (cand[owner_q])   grant[owner_q] = 1'b1;
      end
    end

    always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < P; i++)
        if (grant[i]) win_idx = IDX_W'(i);
      win_tail = |(grant & alloc_if.in_tail_all);
    end

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (|grant) begin
        if (state_q == IDLE) begin
          ptr_d = (win_idx == IDX_W'(P - 1)) ? '0 : win_idx + 1'b1;
          if (!win_tail) begin
            state_d = LOCKED;
            owner_d = win_idx;
          end
        end else if (win_tail) begin
          state_d = IDLE;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end

    assign grant_all[o*P +: P] = grant;
    assign locked[o]           = (state_q == LOCKED);
    assign owner_of[o]         = owner_q;
  end

  always_comb begin
    pop = '0;
    for (int unsigned o = 0; o < P; o++)
      pop = pop | grant_all[o*P +: P];
  end

  always_comb begin
    owned = '0;
    for (int unsigned o = 0; o < P; o++)
      if (locked[o]) owned[owner_of[o]] = 1'b1;
  end

  // A body/tail flit is only legal while some locked output belongs to its input.
  always_comb begin
    err_d = 1'b0;
    for (int unsigned i = 0; i < P; i++) begin
      if (alloc_if.in_valid_all[i]) begin
        if (!legal[i]) err_d = 1'b1;
        if (!alloc_if.in_head_all[i] && !owned[i] &&
            |(alloc_if.route_req_all[i*P +: P] & ~locked))
          err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     proto_err <= 1'b0;
    else if (err_d) proto_err <= 1'b1;
  end

  assign alloc_if.grant_outport_all = grant_all;
  assign alloc_if.in_pop_all        = pop;
  assign out_busy_all               = locked;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: arbitration order, wormhole locking,
// backpressure, parallel grants, protocol errors and asynchronous reset.
module tb_switch_allocator;
  import noc_pkg::*;

  localparam int unsigned P = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [P-1:0] out_busy_all;
  logic         proto_err;
  int           n_checks = 0;
  int           n_errors = 0;

  switch_allocator_if #(.P(P)) bus ();

  switch_allocator #(.P(P)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_if     (bus),
    .out_busy_all (out_busy_all),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [P*P-1:0] gsel(input int unsigned o, input int unsigned i);
    logic [P*P-1:0] v;
    v = '0;
    v[o*P + i] = 1'b1;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.in_valid_all  = '0;
    bus.in_head_all   = '0;
    bus.in_tail_all   = '0;
    bus.route_req_all = '0;
    bus.out_ready_all = '1;
  endtask

  task automatic flit(input int unsigned i, input bit h, input bit t, input int unsigned o);
    bus.in_valid_all[i]        = 1'b1;
    bus.in_head_all[i]         = h;
    bus.in_tail_all[i]         = t;
    bus.route_req_all[i*P +: P] = '0;
    bus.route_req_all[i*P + o] = 1'b1;
  endtask

  task automatic drop(input int unsigned i);
    bus.in_valid_all[i]         = 1'b0;
    bus.route_req_all[i*P +: P] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int unsigned    fair_exp [6] = '{0, 3, 5, 0, 3, 5};
  logic [P*P-1:0] par_exp;

  initial begin
    // Reset with a live request: everything must stay quiet.
    idle_inputs();
    flit(0, 1'b1, 1'b1, 0);
    #3;
    check("rst_grant", 64'(bus.grant_outport_all), 64'h0);
    check("rst_pop", 64'(bus.in_pop_all), 64'h0);
    check("rst_busy", 64'(out_busy_all), 64'h0);
    check("rst_err", 64'(proto_err), 64'h0);
    tick();
    rst_n = 1'b1;

    // Single-flit packet 2 -> 4.
    idle_inputs();
    flit(2, 1'b1, 1'b1, 4);
    settle();
    check("single_grant", 64'(bus.grant_outport_all), 64'(gsel(4, 2)));
    check("single_pop", 64'(bus.in_pop_all), 64'h04);
    tick();
    check("single_busy", 64'(out_busy_all), 64'h0);
    flit(3, 1'b1, 1'b1, 4);
    settle();
    check("single_ptr3", 64'(bus.grant_outport_all), 64'(gsel(4, 3)));
    tick();

    // Fairness on output 1 with wrap-around.
    idle_inputs();
    flit(0, 1'b1, 1'b1, 1);
    flit(3, 1'b1, 1'b1, 1);
    flit(5, 1'b1, 1'b1, 1);
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("fair_%0d", k), 64'(bus.grant_outport_all), 64'(gsel(1, fair_exp[k])));
      tick();
    end

    // Wormhole: 4-flit packet from input 1 holds output 0 against input 6.
    idle_inputs();
    flit(1, 1'b1, 1'b0, 0);
    flit(6, 1'b1, 1'b1, 0);
    settle();
    check("wh_head", 64'(bus.grant_outport_all), 64'(gsel(0, 1)));
    tick();
    for (int k = 0; k < 2; k++) begin
      flit(1, 1'b0, 1'b0, 0);
      settle();
      check($sformatf("wh_body_%0d", k), 64'(bus.grant_outport_all), 64'(gsel(0, 1)));
      check($sformatf("wh_busy_%0d", k), 64'(out_busy_all), 64'h01);
      tick();
    end
    flit(1, 1'b0, 1'b1, 0);
    settle();
    check("wh_tail", 64'(bus.grant_outport_all), 64'(gsel(0, 1)));
    check("wh_tail_busy", 64'(out_busy_all), 64'h01);
    tick();
    drop(1);
    settle();
    check("wh_after_busy", 64'(out_busy_all), 64'h0);
    check("wh_next_owner", 64'(bus.grant_outport_all), 64'(gsel(0, 6)));
    tick();

    // Backpressure then bubble on output 0, owner input 4, input 2 waiting.
    idle_inputs();
    flit(4, 1'b1, 1'b0, 0);
    settle();
    check("bp_head", 64'(bus.grant_outport_all), 64'(gsel(0, 4)));
    tick();
    flit(4, 1'b0, 1'b0, 0);
    flit(2, 1'b1, 1'b1, 0);
    bus.out_ready_all[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("bp_stall_%0d", k), 64'(bus.grant_outport_all), 64'h0);
      check($sformatf("bp_busy_%0d", k), 64'(out_busy_all), 64'h01);
      tick();
    end
    bus.out_ready_all[0] = 1'b1;
    settle();
    check("bp_resume", 64'(bus.grant_outport_all), 64'(gsel(0, 4)));
    tick();
    drop(4);
    settle();
    check("bubble_grant", 64'(bus.grant_outport_all), 64'h0);
    check("bubble_pop", 64'(bus.in_pop_all), 64'h0);
    tick();
    flit(4, 1'b0, 1'b1, 0);
    settle();
    check("bp_tail", 64'(bus.grant_outport_all), 64'(gsel(0, 4)));
    tick();
    drop(4);
    settle();
    check("bp_waiter", 64'(bus.grant_outport_all), 64'(gsel(0, 2)));
    tick();

    // All seven inputs to distinct outputs in one cycle.
    idle_inputs();
    par_exp = '0;
    for (int unsigned i = 0; i < P; i++) begin
      flit(i, 1'b1, 1'b1, (i + 3) % P);
      par_exp = par_exp | gsel((i + 3) % P, i);
    end
    settle();
    check("par_pop", 64'(bus.in_pop_all), 64'h7F);
    check("par_grant", 64'(bus.grant_outport_all), 64'(par_exp));
    tick();
    check("no_false_err", 64'(proto_err), 64'h0);

    // Reset mid-packet drops the lock and pointer.
    idle_inputs();
    flit(5, 1'b1, 1'b0, 6);
    settle();
    check("mid_head", 64'(bus.grant_outport_all), 64'(gsel(6, 5)));
    tick();
    check("mid_busy", 64'(out_busy_all), 64'h40);
    flit(5, 1'b0, 1'b0, 6);
    rst_n = 1'b0;
    settle();
    check("mid_rst_grant", 64'(bus.grant_outport_all), 64'h0);
    check("mid_rst_pop", 64'(bus.in_pop_all), 64'h0);
    check("mid_rst_busy", 64'(out_busy_all), 64'h0);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    flit(0, 1'b1, 1'b1, 6);
    flit(6, 1'b1, 1'b1, 6);
    settle();
    check("ptr_reset", 64'(bus.grant_outport_all), 64'(gsel(6, 0)));
    tick();

    // Multi-hot request from input 3.
    idle_inputs();
    bus.in_valid_all[3]      = 1'b1;
    bus.in_head_all[3]       = 1'b1;
    bus.in_tail_all[3]       = 1'b1;
    bus.route_req_all[21 +: 7] = 7'b0000110;
    settle();
    check("multihot_grant", 64'(bus.grant_outport_all), 64'h0);
    check("multihot_pop", 64'(bus.in_pop_all), 64'h0);
    tick();
    check("multihot_err", 64'(proto_err), 64'h1);

    // Orphan body flit to an idle, unowned output.
    rst_n = 1'b0;
    settle();
    check("err_cleared", 64'(proto_err), 64'h0);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    flit(1, 1'b0, 1'b0, 3);
    settle();
    check("orphan_grant", 64'(bus.grant_outport_all), 64'h0);
    tick();
    check("orphan_err", 64'(proto_err), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Wormhole switch allocator for the router crossbar. Each cycle it arbitrates the P input ports' head flits among the P output ports with per-output round-robin. It holds an output locked to the winning input until that input's tail flit has crossed. It drives the crossbar's one-hot per-output select vector and pops the granted input buffers.

## Interface
Parameters:
- P, 7, number of router ports; inputs and outputs are both indexed 0..P-1.

Ports:
- clk  in  1  router clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid_all  in  P  input buffer i holds a flit at its head.
- in_head_all  in  P  flit at input i is a packet head.
- in_tail_all  in  P  flit at input i is a packet tail; head and tail may both be set for a single-flit packet.
- route_req_all  in  P*P  bits [(i+1)*P-1:i*P] are the one-hot destination output of input i's current packet; all-zero means no request.
- out_ready_all  in  P  output o can accept a flit this cycle (credit available).
- grant_outport_all  out  P*P  bits [(o+1)*P-1:o*P] are the one-hot input select for output o; all-zero means no transfer. Layout matches the crossbar select input.
- in_pop_all  out  P  input i's flit transfers this cycle; buffer dequeues at the clock edge.
- out_busy_all  out  P  registered; output o is locked to a packet.
- proto_err  out  1  sticky protocol-error flag.

## Operation
- Each output has a registered state.
  - State: IDLE or LOCKED.
  - Owner: input index, log2 P bits.
  - Round-robin pointer: log2 P bits.
- Candidate set for output o: inputs i with in_valid_all[i] and route_req_all[i*P+o].
- IDLE, out_ready_all[o]=1:
  - Eligible candidates are those with in_head_all[i]=1.
  - The winner is the first eligible index at or after the pointer, searching upward modulo P.
  - The winner is granted this cycle.
- LOCKED, out_ready_all[o]=1:
  - Granted only when the owner is a candidate.
  - Otherwise the output bubbles; no other input is granted.
- out_ready_all[o]=0: no grant, no state change.
- A transfer on (o,i) sets grant_outport_all[o*P+i]=1 and in_pop_all[i]=1. At the clock edge:
  - head and not tail: state LOCKED, owner i, pointer (i+1) mod P.
  - head and tail: state stays IDLE, pointer (i+1) mod P.
  - LOCKED and tail: state IDLE, pointer unchanged.
  - LOCKED and not tail: no state change.
- Pointer advances only when a packet starts, so packets get fair round-robin service.
- Each input requests at most one output, so an input wins at most one output per cycle; in_pop_all[i] is the OR over outputs of the grants for input i.
- proto_err is set at the clock edge, and stays set until reset, on either of:
  - any route_req_all slice multi-hot while its in_valid_all bit is 1;
  - a valid non-head flit requesting an IDLE output that no LOCKED output owns.
- Illegal requests are never granted.

## Timing
- Grants are combinational from the current registered state and the inputs: zero-cycle allocation.
- A head flit presented to an IDLE, ready output is transferred in the same cycle.
- Body flits stream one per cycle while in_valid_all and out_ready_all hold.
- State, owner, pointer and proto_err update on the rising edge of clk.
- Reset (rst_n low, asynchronous):
  - all states IDLE, owners 0, pointers 0;
  - out_busy_all=0, proto_err=0;
  - grant_outport_all and in_pop_all forced to 0 while rst_n is low.
- Reset mid-packet drops all locks; the input buffers are reset in the same domain.
- Tail transfer and a new head requesting the same output in the same cycle: the new head is not granted until the next cycle. The output is seen as LOCKED for the whole cycle in which the tail crosses.
- out_ready_all dropping mid-packet holds the lock with no grant. The transfer resumes when ready returns, with no re-arbitration.

## Structure
- Shared package noc_pkg:
  - default P;
  - port index width localparam (log2 P);
  - output state enum {IDLE, LOCKED}.
- Sub-module rr_arbiter (P-bit request, pointer in, one-hot grant out), instantiated once per output in a generate loop.
- The lock and owner registers and the error logic stay in switch_allocator.

## Test plan
- Single-flit packet: input 2 head+tail requests output 4, out_ready=1 -> same cycle grant_outport_all[4*P+2]=1, in_pop_all[2]=1; output 4 stays IDLE; its pointer becomes 3.
- Fairness: inputs 0, 3, 5 send back-to-back single-flit packets to output 1, pointer 0 -> grant order 0,3,5,0,3,5.
- Wormhole lock: input 1 sends a 4-flit packet to output 0 while input 6 holds a head for output 0.
  - Input 1 is granted for 4 consecutive cycles with out_busy_all[0]=1.
  - Input 6 is granted on the cycle after the tail.
- Backpressure and bubble:
  - out_ready_all[0]=0 for 3 cycles mid-packet -> no grants, lock held, transfer resumes on the same owner.
  - in_valid of the owner low -> output bubbles and no other input is granted.
- Parallelism: inputs 0..6 each request a distinct output -> all 7 granted in the same cycle, in_pop_all=7'h7F.
- Errors and reset:
  - Multi-hot request on input 3 -> not granted, proto_err=1 next edge.
  - rst_n low mid-packet -> outputs zero immediately, out_busy_all=0, pointers 0.
